// File: rtl/anppv_stack_pkg.sv
// Shared encodings and defaults for the stack pointer / stack memory access path.
package anppv_stack_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic [15:0] STACK_BASE_DEF  = 16'h0100;
  localparam logic [15:0] STACK_LIMIT_DEF = 16'h00F0;
  localparam int unsigned TIMEOUT_DEF     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Memory transaction latched at command accept, held stable through MEM.
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/stack_bounds_check.sv
// Full-descending stack bounds and slot address: push targets SP-1, pop reads SP.
module stack_bounds_check
  import anppv_stack_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic [15:0] sp_i,
  input  logic        op_i,
  output logic        ovf_o,
  output logic        unf_o,
  output logic [15:0] addr_o
);

  assign ovf_o  = (op_i == OP_PUSH) && (sp_i == STACK_LIMIT);
  assign unf_o  = (op_i == OP_POP)  && (sp_i == STACK_BASE);
  assign addr_o = (op_i == OP_PUSH) ? sp_i - 16'd1 : sp_i;

endmodule

// File: rtl/stack_access_unit.sv
// Runs one stack-slot memory transaction per push/pop and reports SP adjust pulses,
// bounds errors and memory timeouts back to the pipeline.
module stack_access_unit
  import anppv_stack_pkg::*;
#(
  parameter logic [15:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [15:0] STACK_LIMIT = STACK_LIMIT_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [15:0] cmd_wdata_i,
  input  logic [15:0] sp_in_i,
  output logic        sp_inc_o,
  output logic        sp_dec_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        err_ovf_o,
  output logic        err_unf_o,
  output logic        err_tmo_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;

  logic        bc_ovf, bc_unf;
  logic [15:0] bc_addr;
  logic        accept, tmo_hit;

  stack_bounds_check #(
    .STACK_BASE (STACK_BASE),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_bounds (
    .sp_i  (sp_in_i),
    .op_i  (cmd_op_i),
    .ovf_o (bc_ovf),
    .unf_o (bc_unf),
    .addr_o(bc_addr)
  );

  // A flush in IDLE blocks acceptance outright; later flushes only discard.
  assign accept  = cmd_valid_i && (state_q == S_IDLE) && !flush_i;
  assign tmo_hit = (state_q == S_MEM) && !mem_ack_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && !bc_ovf && !bc_unf) state_d = S_MEM;
      S_MEM: begin
        if (mem_ack_i)    state_d = S_RESP;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    mem_req_o   = (state_q == S_MEM);
    rsp_valid_o = (state_q == S_RESP) && !discard_q;
    sp_dec_o    = rsp_valid_o && cmd_q.we;
    sp_inc_o    = rsp_valid_o && !cmd_q.we;
  end

  always_comb begin
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    rdata_d   = rdata_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    tmo_d     = 1'b0;
    if (accept) begin
      cmd_d     = '{we: ~cmd_op_i, addr: bc_addr, wdata: cmd_wdata_i};
      cnt_d     = '0;
      discard_d = 1'b0;
      ovf_d     = bc_ovf;
      unf_d     = bc_unf;
    end
    if (state_q == S_MEM) begin
      cnt_d     = cnt_q + 1'b1;
      discard_d = discard_q || flush_i;
      tmo_d     = tmo_hit;
      if (mem_ack_i && !cmd_q.we) rdata_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cmd_q     <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      rdata_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign rsp_rdata_o = rdata_q;
  assign err_ovf_o   = ovf_q;
  assign err_unf_o   = unf_q;
  assign err_tmo_o   = tmo_q;

endmodule

// File: tb/tb_stack_access_unit.sv
// Table-driven bench for stack_access_unit with an event scoreboard on the pulse outputs.
module tb_stack_access_unit;
  import anppv_stack_pkg::*;

  localparam logic [15:0] BASE  = 16'h0100;
  localparam logic [15:0] LIMIT = 16'h00F0;
  localparam int          TMO   = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [15:0] cmd_wdata = '0, sp_in = '0;
  logic        sp_inc, sp_dec, flush = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic        rsp_valid, err_ovf, err_unf, err_tmo;
  logic [15:0] rsp_rdata;

  stack_access_unit #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_wdata_i(cmd_wdata), .sp_in_i(sp_in), .sp_inc_o(sp_inc),
    .sp_dec_o(sp_dec), .flush_i(flush), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .err_ovf_o(err_ovf), .err_unf_o(err_unf), .err_tmo_o(err_tmo)
  );

  always #5 clk = ~clk;

  // flags = {rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo}
  typedef struct {
    logic [5:0]  flags;
    bit          chk_rd;
    logic [15:0] rd;
  } ev_t;

  typedef struct {
    logic        op;
    logic [15:0] sp;
    logic [15:0] wd;
    int          wait_n;
    logic [15:0] rd;
    int          flush_at;
    bit          ack_en;
  } vec_t;

  ev_t  sb_q[$];
  ev_t  mon_e;
  vec_t tbl[10];
  int   n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (rsp_valid || sp_inc || sp_dec || err_ovf || err_unf || err_tmo)) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got flags %b, required no event",
                 {rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo});
      end else begin
        mon_e = sb_q.pop_front();
        if ({rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo} !== mon_e.flags ||
            (mon_e.chk_rd && rsp_rdata !== mon_e.rd)) begin
          n_err++;
          $display("FAIL event: got flags %b rdata %h, required flags %b rdata %h",
                   {rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo}, rsp_rdata,
                   mon_e.flags, mon_e.rd);
        end
      end
    end
  end

  task automatic run_cmd(input vec_t v);
    logic        ovf, unf, disc;
    logic [15:0] ea;
    int          cyc;
    bit          ok, acked;
    ev_t         e;
    ovf  = (v.op == OP_PUSH) && (v.sp == LIMIT);
    unf  = (v.op == OP_POP) && (v.sp == BASE);
    ea   = (v.op == OP_PUSH) ? v.sp - 16'd1 : v.sp;
    disc = v.ack_en && (v.flush_at >= 0) && (v.flush_at <= v.wait_n);
    check("ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = v.op; sp_in = v.sp; cmd_wdata = v.wd;
    e.chk_rd = 1'b0; e.rd = '0;
    if (ovf)              e.flags = 6'b000100;
    else if (unf)         e.flags = 6'b000010;
    else if (!v.ack_en)   e.flags = 6'b000001;
    else if (v.op == OP_PUSH) e.flags = 6'b101000;
    else begin
      e.flags = 6'b110000; e.chk_rd = 1'b1; e.rd = v.rd;
    end
    if (ovf || unf || !v.ack_en || !disc) sb_q.push_back(e);
    step;
    cmd_valid = 1'b0; sp_in = ~v.sp; cmd_wdata = 16'h0BAD;
    if (ovf || unf) begin
      check("no_req_on_reject", 64'(mem_req), 64'd0);
      check("ready_after_reject", 64'(cmd_ready), 64'd1);
      step;
      return;
    end
    cyc = 0; ok = 1'b1; acked = 1'b0;
    while (mem_req && cyc < 64 && !acked) begin
      if (mem_addr !== ea || mem_we !== ~v.op || (v.op == OP_PUSH && mem_wdata !== v.wd)) ok = 1'b0;
      if (v.ack_en && cyc == v.wait_n) begin
        mem_ack = 1'b1; mem_rdata = v.rd; acked = 1'b1;
      end
      if (cyc == v.flush_at) flush = 1'b1;
      step;
      mem_ack = 1'b0; flush = 1'b0; mem_rdata = 16'hDEAD;
      cyc++;
    end
    check("mem_fields", 64'(ok), 64'd1);
    check("req_cycles", 64'(cyc), v.ack_en ? 64'(v.wait_n + 1) : 64'(TMO));
    if (acked) begin
      check("resp_no_req", 64'(mem_req), 64'd0);
      check("resp_not_ready", 64'(cmd_ready), 64'd0);
      step;
    end
    check("ready_after", 64'(cmd_ready), 64'd1);
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    //          op       sp        wdata     wait rdata     flush ack
    tbl[0] = '{OP_PUSH, 16'h0100, 16'hBEEF, 0,  16'h0000, -1, 1'b1};
    tbl[1] = '{OP_POP,  16'h00FF, 16'h0000, 3,  16'hBEEF, -1, 1'b1};
    tbl[2] = '{OP_PUSH, 16'h00F0, 16'h1111, 0,  16'h0000, -1, 1'b1};
    tbl[3] = '{OP_POP,  16'h0100, 16'h0000, 0,  16'h0000, -1, 1'b1};
    tbl[4] = '{OP_POP,  16'h00FF, 16'h0000, 0,  16'h0000, -1, 1'b0};
    tbl[5] = '{OP_PUSH, 16'h00FF, 16'h1234, 2,  16'h0000,  0, 1'b1};
    tbl[6] = '{OP_PUSH, 16'h00F1, 16'h5A5A, 15, 16'h0000, -1, 1'b1};
    tbl[7] = '{OP_POP,  16'h00F1, 16'h0000, 1,  16'hA5C3, -1, 1'b1};
    tbl[8] = '{OP_POP,  16'h00F2, 16'h0000, 1,  16'h1111,  1, 1'b1};
    tbl[9] = '{OP_POP,  16'h00F0, 16'h0000, 0,  16'h7777, -1, 1'b1};

    step; step;
    check("reset_ready", 64'(cmd_ready), 64'd1);
    check("reset_ctl", 64'({mem_req, mem_we, rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo}), 64'd0);
    check("reset_data", 64'({mem_addr, mem_wdata, rsp_rdata}), 64'd0);
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // flush alongside a command in IDLE: the command is dropped
    cmd_valid = 1'b1; cmd_op = OP_PUSH; sp_in = 16'h0100; cmd_wdata = 16'hCAFE; flush = 1'b1;
    step;
    cmd_valid = 1'b0; flush = 1'b0;
    check("flush_idle_no_req", 64'(mem_req), 64'd0);
    check("flush_idle_ready", 64'(cmd_ready), 64'd1);
    step;

    // reset in MEM: request must fall without waiting for a clock edge
    cmd_valid = 1'b1; cmd_op = OP_PUSH; sp_in = 16'h0100; cmd_wdata = 16'h4321;
    step;
    cmd_valid = 1'b0;
    check("req_before_rst", 64'(mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("req_async_drop", 64'(mem_req), 64'd0);
    check("ready_async", 64'(cmd_ready), 64'd1);
    step; step;
    rst_n = 1'b1;
    step;
    check("post_rst_ctl", 64'({cmd_ready, mem_req, rsp_valid, sp_inc, sp_dec, err_ovf, err_unf, err_tmo}),
          64'b1000_0000);
    step;
    run_cmd(tbl[0]);

    step; step;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
